// File: rtl/lut_pkg.sv
// Shared widths, FSM state type and power-on table contents for the reverse LUT search.
package lut_pkg;

    localparam int N_ENTRIES = 64;
    localparam int IDX_W     = $clog2(N_ENTRIES);
    localparam int DATA_W    = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        RESP
    } lut_state_t;

    localparam logic [DATA_W-1:0] LUT_DEFAULT [N_ENTRIES] = '{
        0:       7'd15,
        2:       7'd18,
        5:       7'd19,
        default: 7'd0
    };

endpackage

// File: rtl/lut_reverse_search_if.sv
// Table-write, query and response signals of the reverse LUT search.
interface lut_reverse_search_if;
    import lut_pkg::*;

    logic              wr_en;
    logic [IDX_W-1:0]  wr_index;
    logic [DATA_W-1:0] wr_data;
    logic              q_valid;
    logic              q_ready;
    logic [DATA_W-1:0] q_target;
    logic              r_valid;
    logic              r_ready;
    logic [IDX_W-1:0]  r_index;
    logic              r_hit;

    modport master (
        output wr_en, wr_index, wr_data, q_valid, q_target, r_ready,
        input  q_ready, r_valid, r_index, r_hit
    );

    modport slave (
        input  wr_en, wr_index, wr_data, q_valid, q_target, r_ready,
        output q_ready, r_valid, r_index, r_hit
    );

endinterface

// File: rtl/lut_table.sv
// Writable copy of the index->value table: one write port, one combinational read port.
module lut_table
    import lut_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_index,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_index,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [N_ENTRIES];

    // NOTE: this is a reset register array, not a RAM macro; reset must reload LUT_DEFAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_ENTRIES; i++) begin
                mem[i] <= LUT_DEFAULT[i];
            end
        end else if (wr_en) begin
            mem[wr_index] <= wr_data;
        end
    end

    assign rd_data = mem[rd_index];

endmodule

// File: rtl/lut_reverse_search.sv
// Reverse LUT search: sequential scan for the lowest index holding a target value.
// Optional one-entry result cache enabled by LUT_SEARCH_CACHE_EN.
module lut_reverse_search
    import lut_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    lut_reverse_search_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    lut_state_t        state, state_d;
    logic [IDX_W-1:0]  ptr, ptr_d;
    logic [DATA_W-1:0] target, target_d;
    logic [IDX_W-1:0]  index, index_d;
    logic              hit, hit_d;
    logic [DATA_W-1:0] rd_data;
    logic              match;
    logic              scan_done;

    lut_table u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (bus.wr_en),
        .wr_index (bus.wr_index),
        .wr_data  (bus.wr_data),
        .rd_index (ptr),
        .rd_data  (rd_data)
    );

    // Read port sees the pre-write value, so a same-cycle write never affects this compare.
    assign match     = (rd_data == target);
    assign scan_done = (state == SCAN) && (match || ptr == LAST_IDX);

`ifdef LUT_SEARCH_CACHE_EN
    logic              cache_valid;
    logic [DATA_W-1:0] cache_target;
    logic [IDX_W-1:0]  cache_index;
    logic              cache_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_valid  <= 1'b0;
            cache_target <= '0;
            cache_index  <= '0;
            cache_hit    <= 1'b0;
        end else if (bus.wr_en) begin
            cache_valid <= 1'b0;
        end else if (scan_done) begin
            cache_valid  <= 1'b1;
            cache_target <= target;
            cache_index  <= index_d;
            cache_hit    <= hit_d;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d  = state;
        ptr_d    = ptr;
        target_d = target;
        index_d  = index;
        hit_d    = hit;
        unique case (state)
            IDLE: begin
                if (bus.q_valid) begin
                    target_d = bus.q_target;
                    ptr_d    = '0;
                    state_d  = SCAN;
`ifdef LUT_SEARCH_CACHE_EN
                    // A write this cycle may change the answer, so it bypasses the cache.
                    if (cache_valid && !bus.wr_en && cache_target == bus.q_target) begin
                        index_d = cache_index;
                        hit_d   = cache_hit;
                        state_d = RESP;
                    end
`endif
                end
            end
            SCAN: begin
                if (match) begin
                    index_d = ptr;
                    hit_d   = 1'b1;
                    state_d = RESP;
                end else if (ptr == LAST_IDX) begin
                    index_d = '0;
                    hit_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    ptr_d = ptr + 1'b1;
                end
            end
            RESP: begin
                if (bus.r_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= '0;
            target <= '0;
            index  <= '0;
            hit    <= 1'b0;
        end else begin
            state  <= state_d;
            ptr    <= ptr_d;
            target <= target_d;
            index  <= index_d;
            hit    <= hit_d;
        end
    end

    assign bus.q_ready = (state == IDLE);
    assign bus.r_valid = (state == RESP);
    assign bus.r_index = index;
    assign bus.r_hit   = hit;

endmodule

// File: tb/tb_lut_reverse_search.sv
// Self-checking bench for lut_reverse_search: directed vectors, corner sequences and
// randomized queries/writes against a table-and-cache model.
module tb_lut_reverse_search;
    import lut_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    lut_reverse_search_if bus ();

    lut_reverse_search dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain array of entries plus the last scanned result.
    int  model_tbl [N_ENTRIES];
    bit  c_valid;
    int  c_tgt;
    int  c_idx;
    bit  c_hit;

    typedef struct {
        int target;
        int exp_idx;
        bit exp_hit;
        int exp_lat;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N_ENTRIES; i++) model_tbl[i] = 0;
        model_tbl[0] = 15;
        model_tbl[2] = 18;
        model_tbl[5] = 19;
        c_valid = 1'b0;
    endtask

    task automatic model_query(input int t, output int idx, output bit h, output int lat);
        idx = 0;
        h   = 1'b0;
        lat = N_ENTRIES + 1;
        for (int i = N_ENTRIES - 1; i >= 0; i--) begin
            if (model_tbl[i] == t) begin
                idx = i;
                h   = 1'b1;
                lat = i + 2;
            end
        end
`ifdef LUT_SEARCH_CACHE_EN
        if (c_valid && c_tgt == t) lat = 1;
`endif
        c_valid = 1'b1;
        c_tgt   = t;
        c_idx   = idx;
        c_hit   = h;
    endtask

    task automatic do_write(input int idx, input int data);
        bus.wr_en    = 1'b1;
        bus.wr_index = IDX_W'(idx);
        bus.wr_data  = DATA_W'(data);
        @(posedge clk);
        #1;
        bus.wr_en = 1'b0;
        model_tbl[idx] = data;
        c_valid = 1'b0;
    endtask

    // Issues one query; holds r_ready low for 'hold' cycles once the response appears.
    task automatic run_query(input int t, input int hold, output int idx, output bit h,
                             output int lat, output bit qr_seen, output bit unstable);
        qr_seen  = 1'b0;
        unstable = 1'b0;
        bus.q_valid  = 1'b1;
        bus.q_target = DATA_W'(t);
        @(posedge clk);
        #1;
        bus.q_valid = 1'b0;
        lat = 1;
        while (!bus.r_valid && lat < 200) begin
            if (bus.q_ready) qr_seen = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        if (!bus.r_valid) begin
            check("response_timeout", 0, 1);
            idx = -1;
            h   = 1'b0;
            return;
        end
        idx = int'(bus.r_index);
        h   = bus.r_hit;
        bus.q_valid = (hold > 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!bus.r_valid || int'(bus.r_index) != idx || bus.r_hit != h || bus.q_ready)
                unstable = 1'b1;
        end
        bus.q_valid = 1'b0;
        bus.r_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.r_ready = 1'b0;
        check("q_ready_after_resp", int'(bus.q_ready), 1);
        check("r_valid_after_resp", int'(bus.r_valid), 0);
    endtask

    task automatic query_vs_model(input string name, input int t);
        int e_idx, e_lat, idx, lat;
        bit e_hit, h, qs, us;
        model_query(t, e_idx, e_hit, e_lat);
        run_query(t, 0, idx, h, lat, qs, us);
        check({name, "_idx"}, idx, e_idx);
        check({name, "_hit"}, int'(h), int'(e_hit));
        check({name, "_lat"}, lat, e_lat);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        int idx, lat, e_idx, e_lat;
        bit h, e_hit, qs, us;

        tests = 0;
        fails = 0;
        bus.wr_en    = 1'b0;
        bus.wr_index = '0;
        bus.wr_data  = '0;
        bus.q_valid  = 1'b0;
        bus.q_target = '0;
        bus.r_ready  = 1'b0;
        rst_n        = 1'b1;
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_q_ready", int'(bus.q_ready), 1);
        check("rst_r_valid", int'(bus.r_valid), 0);
        check("rst_r_index", int'(bus.r_index), 0);
        check("rst_r_hit",   int'(bus.r_hit), 0);
        #10;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        vecs[0] = '{target: 18,  exp_idx: 2, exp_hit: 1'b1, exp_lat: 4};
        vecs[1] = '{target: 0,   exp_idx: 1, exp_hit: 1'b1, exp_lat: 3};
        vecs[2] = '{target: 15,  exp_idx: 0, exp_hit: 1'b1, exp_lat: 2};
        vecs[3] = '{target: 19,  exp_idx: 5, exp_hit: 1'b1, exp_lat: 7};
        vecs[4] = '{target: 100, exp_idx: 0, exp_hit: 1'b0, exp_lat: 65};

        for (int i = 0; i < 5; i++) begin
            model_query(vecs[i].target, e_idx, e_hit, e_lat);
            run_query(vecs[i].target, 0, idx, h, lat, qs, us);
            check($sformatf("vec%0d_idx", i), idx, vecs[i].exp_idx);
            check($sformatf("vec%0d_hit", i), int'(h), int'(vecs[i].exp_hit));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
            check($sformatf("vec%0d_q_ready_low", i), int'(qs), 0);
        end

        // Write a new entry, then it must be found at its index.
        do_write(40, 100);
        model_query(100, e_idx, e_hit, e_lat);
        run_query(100, 0, idx, h, lat, qs, us);
        check("wr40_idx", idx, 40);
        check("wr40_hit", int'(h), 1);
        check("wr40_lat", lat, 42);

        // Back-pressure: response held 10 cycles with a competing query pending.
        model_query(18, e_idx, e_hit, e_lat);
        run_query(18, 10, idx, h, lat, qs, us);
        check("bp_idx", idx, 2);
        check("bp_stable", int'(us), 0);

        // Write entry 3 = 19 on the edge where ptr=3 is compared; the old value is used.
        bus.q_valid  = 1'b1;
        bus.q_target = 7'd19;
        @(posedge clk);
        #1;
        bus.q_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            lat++;
        end
        bus.wr_en    = 1'b1;
        bus.wr_index = 6'd3;
        bus.wr_data  = 7'd19;
        while (!bus.r_valid && lat < 200) begin
            @(posedge clk);
            #1;
            bus.wr_en = 1'b0;
            lat++;
        end
        bus.wr_en = 1'b0;
        model_tbl[3] = 19;
        c_valid = 1'b0;
        check("midwr_idx", int'(bus.r_index), 5);
        check("midwr_lat", lat, 7);
        bus.r_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.r_ready = 1'b0;
        query_vs_model("midwr_after", 19);
        check("midwr_after_idx3", c_idx, 3);

        // Reset mid-scan: outputs return at once and the table reverts.
        bus.q_valid  = 1'b1;
        bus.q_target = 7'd100;
        @(posedge clk);
        #1;
        bus.q_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_r_valid", int'(bus.r_valid), 0);
        check("midrst_q_ready", int'(bus.q_ready), 1);
        #10;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        query_vs_model("midrst_100", 100);
        check("midrst_100_miss", int'(c_hit), 0);

`ifdef LUT_SEARCH_CACHE_EN
        run_query(19, 0, idx, h, lat, qs, us);
        check("cache_first_lat", lat, 7);
        run_query(19, 0, idx, h, lat, qs, us);
        check("cache_second_idx", idx, 5);
        check("cache_second_lat", lat, 1);
        do_write(60, 1);
        run_query(19, 0, idx, h, lat, qs, us);
        check("cache_inval_lat", lat, 7);
        c_valid = 1'b1;
        c_tgt   = 19;
        c_idx   = 5;
        c_hit   = 1'b1;
`endif

        // Randomized queries and writes between queries.
        for (int n = 0; n < 40; n++) begin
            int t;
            if ($urandom_range(1, 0) == 1)
                do_write(int'($urandom_range(N_ENTRIES - 1, 0)), int'($urandom_range(127, 0)));
            case ($urandom_range(3, 0))
                0, 1: t = model_tbl[$urandom_range(N_ENTRIES - 1, 0)];
                2:    t = c_valid ? c_tgt : int'($urandom_range(127, 0));
                default: t = int'($urandom_range(127, 0));
            endcase
            query_vs_model($sformatf("rand%0d", n), t);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
